team_12_wb_csr: RTL and testbench
=================================

# team_12_wb_csr

Wishbone classic slave register block between the team_12 bus wrapper and the team_12 core. It decodes 32-bit Wishbone accesses into a small CSR map and buffers host-to-core words in a TX FIFO. It captures one core-to-host result word at a time and raises a maskable interrupt.

## Interface
- BASE_ADDR, 32'h3000_0000, block base; bits [31:8] must match BASE_ADDR[31:8] to select.
- FIFO_DEPTH, 4, TX FIFO entries (power of two, 2..16).
- clk_i  in  1  system clock (wb_clk_i at top).
- nrst  in  1  reset; one clock; reset is asynchronous and active-low.
- cyc_i, stb_i, we_i  in  1 each  Wishbone cycle/strobe/write.
- adr_i  in  32  byte address; [7:2] word offset; [1:0] ignored.
- dat_i  in  32  write data.
- sel_i  in  4  byte-lane enables.
- dat_o  out  32  read data, valid with ack_o.
- ack_o  out  1  single-cycle acknowledge.
- tx_data  out  32  FIFO head to core.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  core accepts head when tx_valid & tx_ready.
- rx_data  in  32  result word from core.
- rx_valid  in  1  one-cycle capture strobe.
- core_en  out  1  CTRL[0].
- core_cfg  out  8  CTRL[15:8].
- irq  out  1  |(IRQ_STAT & IRQ_EN).

## Operation
- Register map, offsets from BASE_ADDR:
  - 0x00 CTRL, RW. Bit 0 enable; bit 1 FLUSH, self-clearing, reads 0; bits [15:8] cfg.
  - 0x04 STATUS, RO. Bit 0 tx_full; bit 1 tx_empty; bit 2 rx_full; bits [8:4] tx_count.
  - 0x08 TX_DATA, WO. Pushes dat_i; reads 0.
  - 0x0C RX_DATA, RO. Returns the holding register and clears rx_full.
  - 0x10 IRQ_EN, RW, bits [3:0].
  - 0x14 IRQ_STAT, W1C, bits [3:0]:
    - bit 0 TX_DRAINED: FIFO went from non-empty to empty.
    - bit 1 RX_AVAIL: word captured.
    - bit 2 TX_OVF: write to a full FIFO.
    - bit 3 RX_OVF: capture while rx_full.
- sel_i applies to CTRL and IRQ_EN byte lanes only.
- TX_DATA pushes only when sel_i == 4'hF. Any other sel_i is acked and ignored.
- Unmapped offsets and non-matching base: the request is still acked, dat_o = 0, and writes have no effect.
- TX FIFO:
  - Push on an accepted TX_DATA write; pop on tx_valid & tx_ready.
  - Full is evaluated before the same-cycle pop. A write to a full FIFO is dropped and sets TX_OVF, even if a pop occurs that cycle.
  - Pointers wrap modulo FIFO_DEPTH. tx_count is 0..FIFO_DEPTH.
- RX holding register:
  - rx_valid loads rx_data, sets rx_full and sets RX_AVAIL.
  - If rx_full is already set and the register is not being read that cycle, the word is overwritten and RX_OVF is set.
  - Capture and RX_DATA read in the same cycle: the read returns the old word and the new word is loaded, so rx_full stays 1.
  - Reading RX_DATA while empty returns 0, no flag.
- IRQ_STAT: a hardware set and a W1C clear of the same bit in the same cycle leave the bit set (set wins).
- FLUSH:
  - Empties the FIFO, clears rx_full and leaves IRQ_STAT unchanged.
  - TX_DRAINED is not set by a flush.
- Reset values:
  - ack_o = 0, dat_o = 0, tx_valid = 0, tx_data = 0.
  - core_en = 0, core_cfg = 0, irq = 0.
  - All registers 0, FIFO empty.

## Timing
- Request accepted when cyc_i & stb_i & ~ack_o.
- ack_o is asserted exactly one cycle after acceptance, for one cycle. Back-to-back accesses therefore take 2 cycles each.
- Write side effects (register update, push, W1C) and read side effects (RX pop) commit on the edge that asserts ack_o.
- dat_o is registered, valid only while ack_o = 1, and 0 otherwise.
- If cyc_i drops before ack, ack_o still fires once and side effects still commit. The master must ignore it.
- Pushed word visible on tx_data/tx_valid the cycle after ack.
- irq is registered, 1 cycle after the IRQ_STAT/IRQ_EN change.
- Async reset mid-transaction: ack_o drops immediately and no side effect commits.

## Structure
- Package team_12_pkg:
  - register offset localparams (CTRL_OFF … IRQ_STAT_OFF);
  - IRQ bit indices;
  - typedef for the CTRL field struct.
- Sub-module team_12_sync_fifo (parameters WIDTH, DEPTH) with outputs full, empty and count. It uses the same clk_i/nrst.
- Everything else (decode, ack FSM IDLE→ACK→IDLE, CSRs, IRQ) lives in team_12_wb_csr.

## Test plan
- Reset: after nrst deassert, read STATUS → 0x0000_0002, IRQ_STAT → 0, irq = 0, core_en = 0.
- CTRL write 0x0000_AB01 with sel 4'b0011 → core_en = 1, core_cfg = 0xAB. Then write 0xFFFF_FF00 with sel 4'b0001 → CTRL reads 0x0000_AB00.
- FIFO fill with tx_ready = 0:
  - Write 0x11, 0x22, 0x33, 0x44 → STATUS tx_count = 4, tx_full = 1.
  - 5th write 0x55 → dropped, IRQ_STAT = 0x4.
  - Set tx_ready = 1 → tx_data sequence 0x11, 0x22, 0x33, 0x44, then IRQ_STAT = 0x5.
- IRQ: IRQ_EN = 0x2; pulse rx_valid with rx_data = 0xDEAD_BEEF → irq = 1.
  - Read RX_DATA → 0xDEAD_BEEF, rx_full = 0.
  - Write IRQ_STAT 0x2 → irq = 0 one cycle later.
- Overflow/simultaneity:
  - Two rx_valid pulses without a read → RX_OVF set, RX_DATA returns the second word.
  - rx_valid coincident with an RX_DATA read → old word returned, rx_full stays 1.
- Reset mid-access: assert nrst low during a TX_DATA write's accept cycle → no push, ack_o = 0, STATUS = 0x2 after release.

Source files
------------

// File: rtl/team_12_pkg.sv
// Shared CSR map, interrupt bit positions and control-field layout for the
// team_12 Wishbone register block.
package team_12_pkg;

  // Byte offsets from the block base. Decode uses bits [7:2].
  localparam logic [7:0] CTRL_OFF     = 8'h00;
  localparam logic [7:0] STATUS_OFF   = 8'h04;
  localparam logic [7:0] TX_DATA_OFF  = 8'h08;
  localparam logic [7:0] RX_DATA_OFF  = 8'h0C;
  localparam logic [7:0] IRQ_EN_OFF   = 8'h10;
  localparam logic [7:0] IRQ_STAT_OFF = 8'h14;

  // IRQ_STAT / IRQ_EN bit positions
  localparam int IRQ_TX_DRAINED = 0;
  localparam int IRQ_RX_AVAIL   = 1;
  localparam int IRQ_TX_OVF     = 2;
  localparam int IRQ_RX_OVF     = 3;

  // CTRL bit positions within byte 0
  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_FLUSH_BIT = 1;

  // Stored CTRL fields; FLUSH is a strobe and is never stored
  typedef struct packed {
    logic [7:0] cfg;
    logic       en;
  } ctrl_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } ack_state_e;

  // CTRL as seen on a bus read: cfg in [15:8], enable in [0], FLUSH reads 0
  function automatic logic [31:0] ctrl_word(ctrl_t c);
    return {16'h0000, c.cfg, 7'h00, c.en};
  endfunction

endpackage

// File: rtl/team_12_sync_fifo.sv
// Single-clock FIFO. Full is judged before any same-cycle pop, so a push
// into a full FIFO is refused even while the head is leaving.
module team_12_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             nrst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  // Head reads 0 when empty so stale storage never leaks to the core
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Storage needs no reset: an entry is only observable after it is pushed
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk_i or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/team_12_wb_csr.sv
// Wishbone classic CSR slave: decodes the register map, feeds host words to
// the core through a TX FIFO, holds one core result word and raises a
// maskable interrupt. Every access is acked exactly one cycle after accept.
module team_12_wb_csr
  import team_12_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        nrst,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_i,
  input  logic [3:0]  sel_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [31:0] rx_data,
  input  logic        rx_valid,
  output logic        core_en,
  output logic [7:0]  core_cfg,
  output logic        irq
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  ack_state_e    state, state_nxt;
  ctrl_t         ctrl;
  logic          rx_full;
  logic [31:0]   rx_hold;
  logic [3:0]    irq_en, irq_stat, irq_set, w1c_mask;
  logic          accept, hit, wr, rd;
  logic [5:0]    woff;
  logic          at_ctrl, at_tx, at_rx, at_ien, at_ist;
  logic          flush, tx_push, tx_pop, tx_full, tx_empty, drained, rx_rd;
  logic [CW-1:0] tx_count;
  logic [31:0]   rd_data;
  logic          unused_adr;

  assign unused_adr = ^adr_i[1:0];

  // Decode; side effects are gated by accept so they commit on the ack edge
  assign accept  = cyc_i & stb_i & (state == ST_IDLE);
  assign hit     = (adr_i[31:8] == BASE_ADDR[31:8]);
  assign woff    = adr_i[7:2];
  assign wr      = accept & we_i & hit;
  assign rd      = accept & ~we_i & hit;
  assign at_ctrl = (woff == CTRL_OFF[7:2]);
  assign at_tx   = (woff == TX_DATA_OFF[7:2]);
  assign at_rx   = (woff == RX_DATA_OFF[7:2]);
  assign at_ien  = (woff == IRQ_EN_OFF[7:2]);
  assign at_ist  = (woff == IRQ_STAT_OFF[7:2]);

  assign flush    = wr & at_ctrl & sel_i[0] & dat_i[CTRL_FLUSH_BIT];
  assign tx_push  = wr & at_tx & (sel_i == 4'hF);
  assign tx_valid = ~tx_empty;
  assign tx_pop   = tx_valid & tx_ready;
  assign rx_rd    = rd & at_rx;
  assign w1c_mask = (wr & at_ist) ? dat_i[3:0] : 4'h0;
  // Last word leaving with nothing arriving; a flush never counts as a drain
  assign drained  = tx_pop & (tx_count == CW'(1)) & ~tx_push & ~flush;

  assign ack_o    = (state == ST_ACK);
  assign core_en  = ctrl.en;
  assign core_cfg = ctrl.cfg;

  team_12_sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i (clk_i),
    .nrst  (nrst),
    .flush (flush),
    .push  (tx_push),
    .wdata (dat_i),
    .pop   (tx_pop),
    .rdata (tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  // Ack state register
  always_ff @(posedge clk_i or negedge nrst) begin
    if (!nrst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Ack next state: one ack cycle per accepted request, then back to idle
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (cyc_i & stb_i) state_nxt = ST_ACK;
      ST_ACK:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Read mux from pre-edge register values; misses read as 0
  always_comb begin
    rd_data = '0;
    if (hit) begin
      case (woff)
        CTRL_OFF[7:2]:     rd_data = ctrl_word(ctrl);
        STATUS_OFF[7:2]:   rd_data = {23'h0, 5'(tx_count), 1'b0, rx_full, tx_empty, tx_full};
        RX_DATA_OFF[7:2]:  rd_data = rx_full ? rx_hold : 32'h0;
        IRQ_EN_OFF[7:2]:   rd_data = {28'h0, irq_en};
        IRQ_STAT_OFF[7:2]: rd_data = {28'h0, irq_stat};
        default:           rd_data = '0;
      endcase
    end
  end

  // Hardware set sources for IRQ_STAT
  always_comb begin
    irq_set                 = '0;
    irq_set[IRQ_TX_DRAINED] = drained;
    irq_set[IRQ_RX_AVAIL]   = rx_valid;
    irq_set[IRQ_TX_OVF]     = tx_push & tx_full;
    irq_set[IRQ_RX_OVF]     = rx_valid & rx_full & ~rx_rd;
  end

  // Registered read data, non-zero only during the ack cycle
  always_ff @(posedge clk_i or negedge nrst) begin
    if (!nrst) dat_o <= '0;
    else       dat_o <= rd ? rd_data : '0;
  end

  // CTRL fields under byte-lane control
  always_ff @(posedge clk_i or negedge nrst) begin
    if (!nrst) begin
      ctrl <= '0;
    end else if (wr & at_ctrl) begin
      if (sel_i[0]) ctrl.en  <= dat_i[CTRL_EN_BIT];
      if (sel_i[1]) ctrl.cfg <= dat_i[15:8];
    end
  end

  // RX holding register; a capture wins over a same-cycle read or flush
  always_ff @(posedge clk_i or negedge nrst) begin
    if (!nrst) begin
      rx_full <= 1'b0;
      rx_hold <= '0;
    end else if (rx_valid) begin
      rx_full <= 1'b1;
      rx_hold <= rx_data;
    end else if (rx_rd | flush) begin
      rx_full <= 1'b0;
    end
  end

  // IRQ enable, status (set wins over W1C) and registered irq line
  always_ff @(posedge clk_i or negedge nrst) begin
    if (!nrst) begin
      irq_en   <= '0;
      irq_stat <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr & at_ien & sel_i[0]) irq_en <= dat_i[3:0];
      irq_stat <= (irq_stat & ~w1c_mask) | irq_set;
      irq      <= |(irq_stat & irq_en);
    end
  end

endmodule

// File: tb/tb_team_12_wb_csr.sv
// Directed bench for team_12_wb_csr: a queue/variable-level model of the
// register block is stepped every clock and compared each cycle, and the
// directed sequence checks hand-computed read values.
module tb_team_12_wb_csr;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] A_CTRL = 32'h3000_0000;
  localparam logic [31:0] A_STAT = 32'h3000_0004;
  localparam logic [31:0] A_TX   = 32'h3000_0008;
  localparam logic [31:0] A_RX   = 32'h3000_000C;
  localparam logic [31:0] A_IEN  = 32'h3000_0010;
  localparam logic [31:0] A_IST  = 32'h3000_0014;

  logic        clk_i = 1'b0, nrst = 1'b0;
  logic        cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0;
  logic [31:0] adr_i = '0, dat_i = '0, rx_data = '0;
  logic [3:0]  sel_i = '0;
  logic        tx_ready = 1'b0, rx_valid = 1'b0;
  logic [31:0] dat_o, tx_data;
  logic        ack_o, tx_valid, core_en, irq;
  logic [7:0]  core_cfg;

  int n_chk = 0, n_pass = 0;

  // model state
  logic [31:0] q[$];
  logic        m_ack, m_en, m_rxf, m_irq;
  logic [7:0]  m_cfg;
  logic [31:0] m_dat, m_rxw;
  logic [3:0]  m_ien, m_stat;

  team_12_wb_csr #(.BASE_ADDR(32'h3000_0000), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .nrst(nrst), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
    .adr_i(adr_i), .dat_i(dat_i), .sel_i(sel_i), .dat_o(dat_o), .ack_o(ack_o),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .core_en(core_en),
    .core_cfg(core_cfg), .irq(irq)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    q.delete();
    m_ack = 0; m_en = 0; m_rxf = 0; m_irq = 0; m_cfg = 0;
    m_dat = 0; m_rxw = 0; m_ien = 0; m_stat = 0;
  endtask

  // One clock of the block's behaviour, from the bus/core inputs at the edge
  task automatic model_step();
    logic       acc, hit, wr, rdq, fl, rxrd, irq_n;
    logic [7:0] off;
    logic [31:0] rv;
    logic [3:0] setb, clr;
    int         s0;
    irq_n = |(m_stat & m_ien);
    acc   = cyc_i && stb_i && !m_ack;
    hit   = (adr_i[31:8] == 24'h30_0000);
    off   = {adr_i[7:2], 2'b00};
    wr    = acc && we_i && hit;
    rdq   = acc && !we_i && hit;
    rv    = 0;
    if (rdq) begin
      case (off)
        8'h00: rv = {16'h0, m_cfg, 7'h0, m_en};
        8'h04: rv = {23'h0, 5'(q.size()), 1'b0, m_rxf, q.size() == 0, q.size() == DEPTH};
        8'h0C: rv = m_rxf ? m_rxw : 32'h0;
        8'h10: rv = {28'h0, m_ien};
        8'h14: rv = {28'h0, m_stat};
        default: rv = 0;
      endcase
    end
    setb = 0;
    s0   = q.size();
    fl   = wr && off == 8'h00 && sel_i[0] && dat_i[1];
    if (s0 > 0 && tx_ready) void'(q.pop_front());
    if (wr && off == 8'h08 && sel_i == 4'hF) begin
      if (s0 == DEPTH) setb[2] = 1'b1;
      else q.push_back(dat_i);
    end
    if (fl) q.delete();
    if (s0 > 0 && q.size() == 0 && !fl) setb[0] = 1'b1;
    if (wr && off == 8'h00) begin
      if (sel_i[0]) m_en  = dat_i[0];
      if (sel_i[1]) m_cfg = dat_i[15:8];
    end
    if (wr && off == 8'h10 && sel_i[0]) m_ien = dat_i[3:0];
    rxrd = rdq && off == 8'h0C;
    if (rx_valid) begin
      if (m_rxf && !rxrd) setb[3] = 1'b1;
      setb[1] = 1'b1;
      m_rxw   = rx_data;
      m_rxf   = 1'b1;
    end else if (rxrd || fl) begin
      m_rxf = 1'b0;
    end
    clr    = (wr && off == 8'h14) ? dat_i[3:0] : 4'h0;
    m_stat = (m_stat & ~clr) | setb;
    m_irq  = irq_n;
    m_ack  = acc;
    m_dat  = rv;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk_i or negedge nrst);
      if (!nrst) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison of every output against the model
  initial begin
    forever begin
      @(negedge clk_i);
      if (nrst) begin
        chk("cyc_ack", 32'(ack_o), 32'(m_ack));
        chk("cyc_dat_o", dat_o, m_dat);
        chk("cyc_tx_valid", 32'(tx_valid), 32'(q.size() != 0));
        chk("cyc_tx_data", tx_data, (q.size() != 0) ? q[0] : 32'h0);
        chk("cyc_core_en", 32'(core_en), 32'(m_en));
        chk("cyc_core_cfg", 32'(core_cfg), 32'(m_cfg));
        chk("cyc_irq", 32'(irq), 32'(m_irq));
      end
    end
  end

  task automatic wb(input logic w, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s, input logic rxv, input logic [31:0] rxd,
                    output logic [31:0] r);
    @(posedge clk_i); #1;
    cyc_i = 1; stb_i = 1; we_i = w; adr_i = a; dat_i = d; sel_i = s;
    if (rxv) begin rx_valid = 1; rx_data = rxd; end
    @(posedge clk_i); #1;
    rx_valid = 0;
    r = dat_o;
    chk("wb_ack", 32'(ack_o), 32'd1);
    cyc_i = 0; stb_i = 0; we_i = 0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    wb(1'b1, a, d, s, 1'b0, 32'h0, r);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string n);
    logic [31:0] r;
    wb(1'b0, a, 32'h0, 4'hF, 1'b0, 32'h0, r);
    chk(n, r, e);
  endtask

  task automatic pulse_rx(input logic [31:0] d);
    @(posedge clk_i); #1;
    rx_valid = 1; rx_data = d;
    @(posedge clk_i); #1;
    rx_valid = 0;
  endtask

  logic [31:0] exp_tx [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
  logic [31:0] r;

  initial begin
    repeat (3) @(posedge clk_i);
    #1 nrst = 1;
    @(negedge clk_i);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_core_en", 32'(core_en), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    rd(A_STAT, 32'h2, "rst_status");
    rd(A_IST, 32'h0, "rst_irq_stat");

    // CTRL byte lanes
    wr(A_CTRL, 32'h0000_AB01, 4'b0011);
    @(negedge clk_i);
    chk("ctrl_en", 32'(core_en), 32'd1);
    chk("ctrl_cfg", 32'(core_cfg), 32'hAB);
    wr(A_CTRL, 32'hFFFF_FF00, 4'b0001);
    rd(A_CTRL, 32'h0000_AB00, "ctrl_lane0");

    // FIFO fill, overflow, drain
    foreach (exp_tx[i]) wr(A_TX, exp_tx[i], 4'hF);
    rd(A_STAT, 32'h41, "fifo_full_status");
    wr(A_TX, 32'h55, 4'hF);
    rd(A_IST, 32'h4, "tx_ovf");
    @(posedge clk_i); #1 tx_ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      chk("drain_order", tx_data, exp_tx[i]);
    end
    rd(A_IST, 32'h5, "tx_drained");
    wr(A_IST, 32'h5, 4'hF);

    // RX interrupt path
    wr(A_IEN, 32'h2, 4'hF);
    pulse_rx(32'hDEAD_BEEF);
    @(posedge clk_i); @(negedge clk_i);
    chk("irq_set", 32'(irq), 32'd1);
    rd(A_RX, 32'hDEAD_BEEF, "rx_read");
    rd(A_STAT, 32'h2, "rx_cleared");
    wr(A_IST, 32'h2, 4'hF);
    @(negedge clk_i);
    chk("irq_lag", 32'(irq), 32'd1);
    @(negedge clk_i);
    chk("irq_clr", 32'(irq), 32'd0);

    // RX overflow
    pulse_rx(32'h1111_0001);
    pulse_rx(32'h2222_0002);
    rd(A_IST, 32'hA, "rx_ovf");
    rd(A_RX, 32'h2222_0002, "rx_ovf_word");
    wr(A_IST, 32'hF, 4'hF);

    // capture coincident with read
    pulse_rx(32'hA5A5_0001);
    wb(1'b0, A_RX, 32'h0, 4'hF, 1'b1, 32'h5A5A_0002, r);
    chk("rx_coinc_old", r, 32'hA5A5_0001);
    rd(A_STAT, 32'h6, "rx_coinc_full");
    rd(A_IST, 32'h2, "rx_coinc_no_ovf");
    rd(A_RX, 32'h5A5A_0002, "rx_coinc_new");
    wr(A_IST, 32'hF, 4'hF);

    // misses, partial TX write, write-only read
    rd(32'h3000_0020, 32'h0, "unmapped");
    wr(32'h4000_0000, 32'h1, 4'hF);
    rd(A_CTRL, 32'h0000_AB00, "bad_base");
    wr(A_TX, 32'h99, 4'h7);
    rd(A_STAT, 32'h2, "tx_partial_sel");
    rd(A_TX, 32'h0, "tx_reads_zero");

    // flush
    tx_ready = 0;
    wr(A_TX, 32'h1, 4'hF);
    wr(A_TX, 32'h2, 4'hF);
    pulse_rx(32'h77);
    rd(A_STAT, 32'h24, "pre_flush");
    wr(A_CTRL, 32'h3, 4'b0001);
    rd(A_STAT, 32'h2, "post_flush");
    rd(A_CTRL, 32'h0000_AB01, "flush_reads0");
    rd(A_IST, 32'h2, "flush_no_drain");

    // async reset during the accept cycle of a TX write
    @(posedge clk_i); #1;
    cyc_i = 1; stb_i = 1; we_i = 1; adr_i = A_TX; dat_i = 32'h77; sel_i = 4'hF;
    #3 nrst = 0;
    #1 chk("rst_mid_ack", 32'(ack_o), 32'd0);
    @(posedge clk_i); #1;
    cyc_i = 0; stb_i = 0; we_i = 0;
    nrst = 1;
    @(negedge clk_i);
    chk("rst_mid_en", 32'(core_en), 32'd0);
    rd(A_STAT, 32'h2, "rst_mid_status");

    repeat (3) @(posedge clk_i);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
